// File: rtl/l2_request_arbiter_if.sv
// rtl/l2_request_arbiter_if.sv - L1 I/D miss ports and L2 controller port bundle
//
// Purpose: groups every handshake/bus signal of the L2 request arbiter.
//   slave  : arbiter view (L1 requests and L2 response in, L1 responses and L2 request out)
//   master : environment view (L1 caches plus L2 controller), directions mirrored
// Signals:
//   i_read/i_addr            I-cache line read request (level) and address
//   i_resp/i_rdata           I-cache completion pulse and returned line
//   d_read/d_write/d_addr    D-cache read / write-back request (level) and address
//   d_wdata                  D-cache write-back line
//   d_resp/d_rdata           D-cache completion pulse and returned line
//   l2_read/l2_write         request to L2 controller
//   l2_addr/l2_wdata         registered address / write line to L2
//   l2_resp/l2_rdata         L2 completion strobe and read line
interface l2_request_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - single-outstanding arbiter from L1 I/D miss ports to L2
//
// Purpose: grants one of the I-cache / D-cache requesters, registers its address, write
//   line and operation, holds a stable request on the L2 port until l2_resp, returns the
//   line to the winner with a one-cycle resp pulse, then re-arbitrates.
// Build option: L2_ARB_RR_EN defined -> round-robin on simultaneous requests;
//   undefined -> fixed priority, D-cache wins ties.
// Ports:
//   clk   system clock, all state on rising edge
//   rst   asynchronous, active-high reset
//   bus   l2_request_arbiter_if.slave: L1 I/D request/response and L2 request/response
module l2_request_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_request_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic              req_i;
  logic              req_d;
  logic              grant_d;

`ifdef L2_ARB_RR_EN
  // 1: last grant went to D, so the next tie goes to I.
  logic              rr_last_d;
`endif

  always_comb begin
    req_i = bus.i_read;
    req_d = bus.d_read | bus.d_write;
`ifdef L2_ARB_RR_EN
    grant_d = req_d & (~req_i | ~rr_last_d);
`else
    grant_d = req_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
`ifdef L2_ARB_RR_EN
      rr_last_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            // Read wins when both d_read and d_write are (illegally) high.
            rd_q    <= bus.d_read;
            wr_q    <= ~bus.d_read;
            state   <= SERVE_D;
`ifdef L2_ARB_RR_EN
            rr_last_d <= 1'b1;
`endif
          end else if (req_i) begin
            addr_q  <= bus.i_addr;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            state   <= SERVE_I;
`ifdef L2_ARB_RR_EN
            rr_last_d <= 1'b0;
`endif
          end
        end
        SERVE_I: begin
          if (bus.l2_resp) begin
            i_rdata_q <= bus.l2_rdata;
            i_resp_q  <= 1'b1;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            state     <= RESP_I;
          end
        end
        SERVE_D: begin
          if (bus.l2_resp) begin
            d_rdata_q <= bus.l2_rdata;
            d_resp_q  <= 1'b1;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            state     <= RESP_D;
          end
        end
        RESP_I: begin
          i_resp_q <= 1'b0;
          state    <= IDLE;
        end
        RESP_D: begin
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l2_read  = rd_q;
  assign bus.l2_write = wr_q;
  assign bus.l2_addr  = addr_q;
  assign bus.l2_wdata = wdata_q;
  assign bus.i_resp   = i_resp_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_resp   = d_resp_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
